// File: rtl/mcp_sched_pkg.sv
// Shared types and constants for the multicycle path scheduler.
package mcp_sched_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Requester identifiers as carried on result_src / win_src
    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    // Largest legal setup multiplier
    localparam int MCP_CYCLES_MAX = 15;

endpackage

// File: rtl/mcp_rr_arbiter.sv
// Two-way arbiter for the multicycle path scheduler.
// Build option MCP_RR_ARB_EN: round-robin on ties (A wins the first tie);
// otherwise fixed priority with A above B and no state at all.
module mcp_rr_arbiter
    import mcp_sched_pkg::*;
(
`ifdef MCP_RR_ARB_EN
    input  logic clk1,
    input  logic rst,
`endif
    input  logic req_a,
    input  logic req_b,
    input  logic enable,
    output logic gnt_a,
    output logic gnt_b,
    output logic win_src
);

`ifdef MCP_RR_ARB_EN
    logic last_grant_reg;

    // Remember who was served last so a tie goes to the other side
    always_ff @(posedge clk1) begin
        if (rst) begin
            last_grant_reg <= SRC_B;
        end else if (gnt_a || gnt_b) begin
            last_grant_reg <= win_src;
        end
    end

    // Winner selection: alternate on ties, otherwise whoever is asking
    always_comb begin
        win_src = SRC_A;
        if (req_a && req_b) begin
            win_src = (last_grant_reg == SRC_B) ? SRC_A : SRC_B;
        end else if (req_b) begin
            win_src = SRC_B;
        end
    end
`else
    // Winner selection: A always beats B
    always_comb begin
        win_src = req_a ? SRC_A : SRC_B;
    end
`endif

    // Grants only fire while the scheduler can accept a new operation
    always_comb begin
        gnt_a = enable && req_a && (win_src == SRC_A);
        gnt_b = enable && req_b && (win_src == SRC_B);
    end

endmodule

// File: rtl/multicycle_path_scheduler.sv
// Two-requester scheduler for a shared multicycle datapath: grants one
// requester, launches its operand from path_in, waits MCP_CYCLES cycles,
// captures path_out into result and hands it off with valid/ready.
// Build option MCP_RR_ARB_EN selects round-robin instead of fixed priority.
// MCP_CYCLES outside 1..MCP_CYCLES_MAX is rejected at elaboration.
module multicycle_path_scheduler
    import mcp_sched_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MCP_CYCLES = 2
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    output logic             gnt_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    output logic             gnt_b,
    output logic [WIDTH-1:0] path_in,
    input  logic [WIDTH-1:0] path_out,
    output logic             mcp_active,
    output logic [WIDTH-1:0] result,
    output logic             result_src,
    output logic             result_valid,
    input  logic             result_ready
);

    localparam int CNT_W = $clog2(MCP_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MCP_CYCLES - 1);

    if ((MCP_CYCLES < 1) || (MCP_CYCLES > MCP_CYCLES_MAX)) begin : g_bad_mcp
        $error("multicycle_path_scheduler: MCP_CYCLES must be 1..15");
    end

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [WIDTH-1:0]  path_in_reg;
    logic [WIDTH-1:0]  result_reg;
    logic              result_src_reg;
    logic              result_valid_reg, result_valid_next;
    logic              launch;
    logic              capture;
    logic              arb_enable;
    logic              win_src;

    // A request in reset would be discarded anyway, so do not show a grant
    assign arb_enable = (state_reg == IDLE) && !rst;

    mcp_rr_arbiter u_arb (
`ifdef MCP_RR_ARB_EN
        .clk1    (clk1),
        .rst     (rst),
`endif
        .req_a   (req_a),
        .req_b   (req_b),
        .enable  (arb_enable),
        .gnt_a   (gnt_a),
        .gnt_b   (gnt_b),
        .win_src (win_src)
    );

    // State, window counter and valid flag
    always_ff @(posedge clk1) begin
        if (rst) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            result_valid_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            result_valid_reg <= result_valid_next;
        end
    end

    // Next-state logic; launch/capture strobes qualify the data registers
    always_comb begin
        state_next        = state_reg;
        cnt_next          = cnt_reg;
        result_valid_next = result_valid_reg;
        launch            = 1'b0;
        capture           = 1'b0;
        case (state_reg)
            IDLE: begin
                if (gnt_a || gnt_b) begin
                    launch     = 1'b1;
                    cnt_next   = CNT_LOAD;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end else begin
                    capture           = 1'b1;
                    result_valid_next = 1'b1;
                    state_next        = DONE;
                end
            end
            DONE: begin
                if (result_ready) begin
                    result_valid_next = 1'b0;
                    state_next        = IDLE;
                end
            end
            default: begin
                state_next        = IDLE;
                cnt_next          = '0;
                result_valid_next = 1'b0;
            end
        endcase
    end

    // Launch register only moves on a grant edge, keeping the window stable
    always_ff @(posedge clk1) begin
        if (rst) begin
            path_in_reg    <= '0;
            result_src_reg <= SRC_A;
        end else if (launch) begin
            path_in_reg    <= (win_src == SRC_B) ? data_b : data_a;
            result_src_reg <= win_src;
        end
    end

    // Capture register samples the slow logic at the end of the window
    always_ff @(posedge clk1) begin
        if (rst) begin
            result_reg <= '0;
        end else if (capture) begin
            result_reg <= path_out;
        end
    end

    assign path_in      = path_in_reg;
    assign result       = result_reg;
    assign result_src   = result_src_reg;
    assign result_valid = result_valid_reg;
    assign mcp_active   = (state_reg == WAIT);

endmodule

// File: tb/tb_multicycle_path_scheduler.sv
// Directed scoreboard bench for multicycle_path_scheduler (MCP_CYCLES=2
// main instance plus an MCP_CYCLES=1 boundary instance).
module tb_multicycle_path_scheduler;

    typedef struct packed {
        logic [7:0] res;
        logic       src;
    } exp_t;

    logic       clk1;
    logic       rst;
    logic       req_a, req_b, gnt_a, gnt_b;
    logic [7:0] data_a, data_b, path_in, path_out, result;
    logic       mcp_active, result_src, result_valid, result_ready;
    logic       po_force;
    logic [7:0] po_val;

    logic       req1_a, req1_b, gnt1_a, gnt1_b;
    logic [7:0] data1_a, data1_b, path1_in, path1_out, result1;
    logic       mcp1_active, result1_src, result1_valid, result1_ready;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks;
    int   failures;

    // Stand-in for the slow combinational logic
    function automatic logic [7:0] slow_fn(input logic [7:0] x);
        return {x[3:0], x[7:4]} ^ 8'h5A;
    endfunction

    assign path_out  = po_force ? po_val : slow_fn(path_in);
    assign path1_out = slow_fn(path1_in);

    multicycle_path_scheduler #(.WIDTH(8), .MCP_CYCLES(2)) u_dut (
        .clk1(clk1), .rst(rst),
        .req_a(req_a), .data_a(data_a), .gnt_a(gnt_a),
        .req_b(req_b), .data_b(data_b), .gnt_b(gnt_b),
        .path_in(path_in), .path_out(path_out), .mcp_active(mcp_active),
        .result(result), .result_src(result_src),
        .result_valid(result_valid), .result_ready(result_ready)
    );

    multicycle_path_scheduler #(.WIDTH(8), .MCP_CYCLES(1)) u_dut1 (
        .clk1(clk1), .rst(rst),
        .req_a(req1_a), .data_a(data1_a), .gnt_a(gnt1_a),
        .req_b(req1_b), .data_b(data1_b), .gnt_b(gnt1_b),
        .path_in(path1_in), .path_out(path1_out), .mcp_active(mcp1_active),
        .result(result1), .result_src(result1_src),
        .result_valid(result1_valid), .result_ready(result1_ready)
    );

    initial begin
        clk1 = 1'b0;
        forever #5 clk1 = ~clk1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic settle();
        @(negedge clk1);
    endtask

    // Scoreboard: every completed handshake must match the oldest expectation
    always @(negedge clk1) begin
        if (result_valid === 1'b1 && result_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'(sb_q.size()), 1);
            end else begin
                mon_e = sb_q.pop_front();
                $display("TXN src=%0d result=%02h expected_src=%0d expected_result=%02h",
                         result_src, result, mon_e.src, mon_e.res);
                chk("sb_result", 32'(result), 32'(mon_e.res));
                chk("sb_src", 32'(result_src), 32'(mon_e.src));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        logic exp_src;
        checks = 0;
        failures = 0;
        rst = 1'b1;
        req_a = 0; req_b = 0; data_a = 0; data_b = 0; result_ready = 0;
        po_force = 0; po_val = 0;
        req1_a = 0; req1_b = 0; data1_a = 0; data1_b = 0; result1_ready = 1;
        repeat (3) @(posedge clk1);
        #1 rst = 1'b0;
        settle();
        chk("rst_gnt_a", 32'(gnt_a), 0);
        chk("rst_gnt_b", 32'(gnt_b), 0);
        chk("rst_mcp_active", 32'(mcp_active), 0);
        chk("rst_path_in", 32'(path_in), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_result_valid", 32'(result_valid), 0);

        // Single op
        tick(); req_a = 1; data_a = 8'h3C; po_force = 1; po_val = 8'hA5; result_ready = 1;
        sb_q.push_back('{res: 8'hA5, src: 1'b0});
        settle(); chk("t1_gnt_a", 32'(gnt_a), 1); chk("t1_gnt_b", 32'(gnt_b), 0);
        chk("t1_mcp_c0", 32'(mcp_active), 0);
        tick(); req_a = 0;
        settle(); chk("t1_path_in", 32'(path_in), 8'h3C); chk("t1_mcp_c1", 32'(mcp_active), 1);
        tick(); settle(); chk("t1_mcp_c2", 32'(mcp_active), 1);
        tick(); settle();
        chk("t1_valid_c3", 32'(result_valid), 1); chk("t1_result", 32'(result), 8'hA5);
        chk("t1_src", 32'(result_src), 0); chk("t1_mcp_c3", 32'(mcp_active), 0);
        tick(); settle(); chk("t1_valid_c4", 32'(result_valid), 0);

        // Window integrity
        tick(); req_a = 1; data_a = 8'h77; po_val = 8'h00;
        sb_q.push_back('{res: 8'hFF, src: 1'b0});
        settle(); chk("t2_gnt_a", 32'(gnt_a), 1);
        tick(); req_a = 0; po_val = 8'hFF;
        settle(); chk("t2_path_in_c1", 32'(path_in), 8'h77);
        tick(); settle(); chk("t2_path_in_c2", 32'(path_in), 8'h77);
        tick(); po_val = 8'h11;
        settle(); chk("t2_path_in_c3", 32'(path_in), 8'h77); chk("t2_result", 32'(result), 8'hFF);
        tick(); po_force = 0;
        settle(); chk("t2_valid_c4", 32'(result_valid), 0);

        // Backpressure with B pending
        tick(); req_a = 1; data_a = 8'hC3; result_ready = 0;
        sb_q.push_back('{res: slow_fn(8'hC3), src: 1'b0});
        settle(); chk("t3_gnt_a", 32'(gnt_a), 1);
        tick(); req_a = 0; req_b = 1; data_b = 8'h5E;
        settle(); chk("t3_no_gnt_b_wait", 32'(gnt_b), 0);
        tick(); settle(); chk("t3_no_gnt_b_wait2", 32'(gnt_b), 0);
        for (int i = 0; i < 10; i++) begin
            tick(); settle();
            chk("t3_valid_hold", 32'(result_valid), 1);
            chk("t3_no_gnt_b", 32'(gnt_b), 0);
            chk("t3_path_in_hold", 32'(path_in), 8'hC3);
            chk("t3_result_hold", 32'(result), 32'(slow_fn(8'hC3)));
            chk("t3_src_hold", 32'(result_src), 0);
        end
        tick(); result_ready = 1;
        settle(); chk("t3_no_gnt_b_done", 32'(gnt_b), 0);
        tick(); sb_q.push_back('{res: slow_fn(8'h5E), src: 1'b1});
        settle(); chk("t3_gnt_b", 32'(gnt_b), 1); chk("t3_gnt_a", 32'(gnt_a), 0);
        tick(); req_b = 0;
        tick(); tick(); settle(); chk("t3_src_b", 32'(result_src), 1);

        // Contention
        for (int i = 0; i < 4; i++) begin
`ifdef MCP_RR_ARB_EN
            exp_src = 1'(i % 2);
`else
            exp_src = 1'b0;
`endif
            tick(); req_a = 1; req_b = 1; data_a = 8'(8'h10 + i); data_b = 8'(8'h80 + i);
            sb_q.push_back('{res: slow_fn(exp_src ? data_b : data_a), src: exp_src});
            settle();
            chk("t4_gnt_a", 32'(gnt_a), 32'(!exp_src));
            chk("t4_gnt_b", 32'(gnt_b), 32'(exp_src));
            tick(); tick(); tick(); settle();
            chk("t4_src", 32'(result_src), 32'(exp_src));
        end
        tick(); req_a = 0; req_b = 0;
        settle(); chk("t4_idle_no_gnt", 32'(gnt_a | gnt_b), 0);

        // Reset mid-WAIT
        tick(); req_a = 1; data_a = 8'h99;
        settle(); chk("t5_gnt_a", 32'(gnt_a), 1);
        tick(); req_a = 0; rst = 1;
        settle(); chk("t5_mcp_before_rst", 32'(mcp_active), 1);
        tick(); rst = 0;
        settle();
        chk("t5_rst_mcp", 32'(mcp_active), 0);
        chk("t5_rst_path_in", 32'(path_in), 0);
        chk("t5_rst_result", 32'(result), 0);
        chk("t5_rst_src", 32'(result_src), 0);
        chk("t5_rst_valid", 32'(result_valid), 0);
        chk("t5_rst_gnts", 32'({gnt_a, gnt_b}), 0);
        tick(); req_a = 1; data_a = 8'h2D;
        sb_q.push_back('{res: slow_fn(8'h2D), src: 1'b0});
        settle(); chk("t5_regnt_a", 32'(gnt_a), 1);
        tick(); req_a = 0; settle(); chk("t5_mcp_c1", 32'(mcp_active), 1);
        tick(); settle(); chk("t5_mcp_c2", 32'(mcp_active), 1);
        tick(); settle(); chk("t5_mcp_c3", 32'(mcp_active), 0); chk("t5_valid_c3", 32'(result_valid), 1);
        tick(); settle(); chk("t5_valid_c4", 32'(result_valid), 0);

        // MCP_CYCLES = 1 boundary
        tick(); req1_a = 1; data1_a = 8'h4B;
        settle(); chk("t6_gnt_a", 32'(gnt1_a), 1); chk("t6_mcp_c0", 32'(mcp1_active), 0);
        tick(); req1_a = 0;
        settle(); chk("t6_mcp_c1", 32'(mcp1_active), 1); chk("t6_valid_c1", 32'(result1_valid), 0);
        chk("t6_path_in", 32'(path1_in), 8'h4B);
        tick(); settle();
        chk("t6_mcp_c2", 32'(mcp1_active), 0); chk("t6_valid_c2", 32'(result1_valid), 1);
        chk("t6_result", 32'(result1), 32'(slow_fn(8'h4B))); chk("t6_src", 32'(result1_src), 0);
        tick(); settle(); chk("t6_valid_c3", 32'(result1_valid), 0);

        tick();
        chk("sb_drained", 32'(sb_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
